// File: rtl/mem_pkg.sv
// Shared encodings for the memory access controller: request opcodes, FSM states, default widths.
// Purely declarative; no latency or flow-control of its own.
package mem_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      OP_FETCH = 2'b00,
      OP_LOAD  = 2'b01,
      OP_STORE = 2'b10,
      OP_RSVD  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_t;

   // Ops that actually touch Memory.
   function automatic logic isMemOp(input op_t op);
      return op != OP_RSVD;
   endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory port initiator: MEM_LAT+2 cycles per request, req_ready low while busy (no queueing).
// MEM_ALIGN_CHECK_EN rejects non-word-aligned requests with rsp_err and no strobes.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] ir_out,
   output logic [DATA_W-1:0] mdr_out,
   output logic              busy,
   output logic              memWrite,
   output logic              memRead,
   output logic              IRWrite,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] writeData,
   input  logic [DATA_W-1:0] readData,
   input  logic [DATA_W-1:0] readInst
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef struct packed {
      op_t               op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t           state, stateNxt;
   req_t             reqQ;
   logic [CNT_W-1:0] cnt, cntNxt;
   logic             memReadQ, memReadNxt;
   logic             memWriteQ, memWriteNxt;
   logic             irWriteQ, irWriteNxt;
   logic             errQ, errNxt;
   logic             accept, badReq, misaligned, accessDone;
   op_t              reqOp;

   assign reqOp = op_t'(req_op);

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = req_addr[1:0] != 2'b00;
`else
   assign misaligned = 1'b0;
`endif

   assign accept     = req_valid && (state == IDLE);
   assign badReq     = !isMemOp(reqOp) || misaligned;
   assign accessDone = (state == ACCESS) && (cnt == '0);

   // Strobe next-values are computed for the cycle being entered so the outputs come straight from flops.
   always_comb begin
      stateNxt    = state;
      cntNxt      = cnt;
      memReadNxt  = 1'b0;
      memWriteNxt = 1'b0;
      irWriteNxt  = 1'b0;
      errNxt      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (badReq) begin
                  stateNxt = RESP;
                  errNxt   = 1'b1;
               end else begin
                  stateNxt    = ACCESS;
                  cntNxt      = CNT_W'(MEM_LAT - 1);
                  irWriteNxt  = reqOp == OP_FETCH;
                  memReadNxt  = reqOp == OP_LOAD;
                  memWriteNxt = reqOp == OP_STORE;
               end
            end
         end
         ACCESS: begin
            if (cnt == '0) begin
               stateNxt = RESP;
            end else begin
               cntNxt     = cnt - CNT_W'(1);
               irWriteNxt = reqQ.op == OP_FETCH;
               memReadNxt = reqQ.op == OP_LOAD;
            end
         end
         RESP:    stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         memReadQ  <= 1'b0;
         memWriteQ <= 1'b0;
         irWriteQ  <= 1'b0;
         errQ      <= 1'b0;
      end else begin
         state     <= stateNxt;
         cnt       <= cntNxt;
         memReadQ  <= memReadNxt;
         memWriteQ <= memWriteNxt;
         irWriteQ  <= irWriteNxt;
         errQ      <= errNxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reqQ <= '0;
      end else if (accept) begin
         reqQ.op    <= reqOp;
         reqQ.addr  <= req_addr;
         reqQ.wdata <= req_wdata;
      end
   end

   // IR/MDR only move on the last access cycle of their own op type.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_out  <= '0;
         mdr_out <= '0;
      end else if (accessDone) begin
         if (reqQ.op == OP_FETCH) ir_out  <= readInst;
         if (reqQ.op == OP_LOAD)  mdr_out <= readData;
      end
   end

   assign req_ready = state == IDLE;
   assign busy      = state != IDLE;
   assign rsp_valid = state == RESP;
   assign rsp_err   = errQ;
   assign memRead   = memReadQ;
   assign memWrite  = memWriteQ;
   assign IRWrite   = irWriteQ;
   assign address   = reqQ.addr;
   assign writeData = reqQ.wdata;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the multicycle processor's unified Memory port.
- Accepts fetch, load and store requests from the datapath/control unit over a valid/ready handshake.
- Sequences memWrite/memRead/IRWrite/address/writeData into Memory.
- Captures readInst into the instruction register (IR) and readData into the memory data register (MDR), then returns a one-cycle response pulse.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles strobes are held before read data is sampled (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_op  in  2  00 fetch, 01 load, 10 store, 11 reserved
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  error qualifier, valid with rsp_valid
- ir_out  out  DATA_W  instruction register
- mdr_out  out  DATA_W  memory data register
- busy  out  1  high whenever state != IDLE
- memWrite  out  1  to Memory
- memRead  out  1  to Memory
- IRWrite  out  1  to Memory
- address  out  ADDR_W  to Memory
- writeData  out  DATA_W  to Memory
- readData  in  DATA_W  from Memory
- readInst  in  DATA_W  from Memory

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; all strobes 0; address=0; writeData=0; ir_out=0; mdr_out=0; rsp_valid=0; rsp_err=0; busy=0; req_ready=1.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge N: latch op, addr and wdata; load counter with MEM_LAT-1; go to ACCESS.
- ACCESS (cycles N+1 .. N+MEM_LAT):
  - address and writeData driven from latched values.
  - Fetch: IRWrite=1, memRead=0, memWrite=0.
  - Load: memRead=1, IRWrite=0, memWrite=0.
  - Store: memWrite=1 in the first ACCESS cycle only, 0 after; data reaches memory on that edge.
  - Reserved op: no strobes; skip ACCESS and go directly to RESP.
  - Counter decrements each cycle; when 0, go to RESP.
  - On that transition edge: fetch writes readInst into ir_out; load writes readData into mdr_out.
- RESP (cycle N+MEM_LAT+1):
  - rsp_valid=1 for exactly one cycle.
  - rsp_err=1 only for reserved op.
  - Strobes 0; req_ready=0; return to IDLE.
- Throughput and latency:
  - One request per MEM_LAT+2 cycles.
  - req_ready is low in ACCESS and RESP; requests presented then are ignored (not queued).
- Output stability:
  - ir_out/mdr_out hold until the next fetch/load completes.
  - A store never alters ir_out/mdr_out.
- Strobe exclusivity: memWrite, memRead and IRWrite are never high simultaneously. Strobes are registered outputs, glitch-free.
- address/writeData hold their last value in IDLE (not forced to 0).
- Reset mid-operation: all strobes drop immediately; in-flight request dropped with no rsp_valid; IR/MDR cleared.
- req_op/req_addr changes after acceptance have no effect.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: on acceptance, if req_addr[1:0]!=0, no strobes are issued. Controller goes IDLE->RESP with rsp_err=1. IR/MDR are unchanged.
- Undefined: address low bits are passed through unchecked; rsp_err asserts only for reserved op.

Decomposition:
- Shared package mem_pkg:
  - op encodings OP_FETCH=2'b00, OP_LOAD=2'b01, OP_STORE=2'b10, OP_RSVD=2'b11
  - state enum (IDLE/ACCESS/RESP)
  - default ADDR_W/DATA_W
- No sub-module is needed. The latency counter is inline.

Test Plan:
- Store then load, MEM_LAT=1: store addr=10, wdata=0x00400020 -> memWrite high exactly 1 cycle at edge N+1, rsp_valid at N+2. Then load addr=10 -> memRead high 1 cycle, mdr_out=0x00400020, rsp_err=0.
- Fetch addr=16 with Memory preloaded 0x01095020 -> IRWrite high, memRead low; ir_out=0x01095020; mdr_out unchanged.
- MEM_LAT=3 load -> memRead high 3 consecutive cycles, rsp_valid on the 4th cycle after acceptance. req_valid held high throughout -> second request accepted only after RESP.
- Reserved op 2'b11 -> no strobes ever high, rsp_valid one cycle after acceptance with rsp_err=1.
- rst_n pulled low during ACCESS of a load -> memRead falls asynchronously, no rsp_valid, mdr_out=0, req_ready=1 after release.
- MEM_ALIGN_CHECK_EN defined, load addr=0x0000000A -> no strobes, rsp_err=1. Same stimulus without the macro -> normal load.
